// File: rtl/pattern_cascade_pkg.sv
// Shared types and the per-stage mixing function for the pattern cascade pipe.
package pattern_cascade_pkg;

    // Widest data path the mix function supports.
    localparam int unsigned MAX_W = 64;
    localparam int unsigned IDX_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_NOR  = 2'd1,
        MODE_NAND = 2'd2,
        MODE_ROTL = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Mixes the low w bits of x; neighbour indices wrap modulo w.
    // Bits at or above w are returned as zero.
    function automatic logic [MAX_W-1:0] mix(input logic [MAX_W-1:0] x,
                                             input mode_t mode,
                                             input int unsigned w);
        logic [MAX_W-1:0] y;
        logic [IDX_W-1:0] i_idx;
        logic [IDX_W-1:0] j_idx;
        logic [IDX_W-1:0] p_idx;
        y = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                i_idx = IDX_W'(i);
                j_idx = IDX_W'((i + 1) % w);
                p_idx = IDX_W'((i + w - 1) % w);
                case (mode)
                    MODE_PASS: y[i_idx] = x[i_idx];
                    MODE_NOR:  y[i_idx] = ~(x[i_idx] | x[j_idx]);
                    MODE_NAND: y[i_idx] = ~(x[i_idx] & x[j_idx]);
                    MODE_ROTL: y[i_idx] = x[p_idx];
                    default:   y[i_idx] = x[i_idx];
                endcase
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/pattern_cascade_stage.sv
// One register stage of the cascade: captures mix(src) together with the item's mode.
module pattern_cascade_stage
    import pattern_cascade_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             src_valid,
    input  mode_t            src_mode,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output mode_t            mode,
    output logic [WIDTH-1:0] data
);

    // Shift on enable; empty slots carry zero data so nothing stale is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            mode  <= MODE_PASS;
            data  <= '0;
        end else if (enable) begin
            valid <= src_valid;
            if (src_valid) begin
                mode <= src_mode;
                data <= WIDTH'(mix(MAX_W'(src_data), src_mode, WIDTH));
            end else begin
                mode <= MODE_PASS;
                data <= '0;
            end
        end
    end

endmodule

// File: rtl/pattern_cascade_pipe.sv
// DEPTH-stage mixing cascade with valid/ready handshake, global stall,
// flush controller, running XOR signature and saturating handshake counter.
module pattern_cascade_pipe
    import pattern_cascade_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] sig,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    logic             adv;
    logic             accept;
    logic             any_valid;
    logic             clear;
    logic [DEPTH-1:0] stage_valid;
    mode_t            stage_mode [DEPTH];
    logic [WIDTH-1:0] stage_data [DEPTH];
    state_t           state;
    state_t           state_next;

    assign adv       = ~out_valid | out_ready;
    assign any_valid = |stage_valid;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            pattern_cascade_stage #(.WIDTH(WIDTH)) u_stage (
                .clk       (blif_clk_net),
                .rst_n     (blif_reset_net),
                .enable    (adv),
                .src_valid (accept),
                .src_mode  (mode_t'(in_mode)),
                .src_data  (in_data),
                .valid     (stage_valid[k]),
                .mode      (stage_mode[k]),
                .data      (stage_data[k])
            );
        end else begin : g_next
            pattern_cascade_stage #(.WIDTH(WIDTH)) u_stage (
                .clk       (blif_clk_net),
                .rst_n     (blif_reset_net),
                .enable    (adv),
                .src_valid (stage_valid[k-1]),
                .src_mode  (stage_mode[k-1]),
                .src_data  (stage_data[k-1]),
                .valid     (stage_valid[k]),
                .mode      (stage_mode[k]),
                .data      (stage_data[k])
            );
        end
    end

    // FSM state register.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; RUN leaves as soon as the pipeline will be empty after this edge.
    always_comb begin
        logic next_any;
        next_any = accept;
        for (int unsigned k = 0; k < DEPTH - 1; k++) begin
            next_any = next_any | stage_valid[k];
        end
        if (!adv) begin
            next_any = any_valid;
        end
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (flush) begin
                    state_next = ST_FLUSH;
                end else if (accept) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_next = ST_FLUSH;
                end else if (!next_any) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (!any_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake and status outputs; the clear fires on the empty FLUSH cycle.
    always_comb begin
        in_ready = adv & ~flush & (state != ST_FLUSH);
        accept   = in_valid & in_ready;
        busy     = (state != ST_IDLE);
        clear    = (state == ST_FLUSH) & ~any_valid;
    end

    // Signature and saturating handshake counter.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            sig   <= '0;
            count <= '0;
        end else if (clear) begin
            sig   <= '0;
            count <= '0;
        end else if (out_valid && out_ready) begin
            sig <= sig ^ out_data;
            if (count != '1) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
